// File: rtl/sequence_checker.sv
// Sequence checker: hunts for the AF start byte, then checks each qualified byte
// against the fixed 8-byte pattern. Stats counters exist only with SEQ_CHECKER_STATS_EN.
module sequence_checker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic             seq_done,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] seq_count,
    output logic             dbg_state,
    output logic [2:0]       dbg_idx
);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [7:0] START_BYTE = 8'hAF;

    state_t     r_state;
    state_t     w_nxt_state;
    logic [2:0] r_idx;
    logic [2:0] w_nxt_idx;
    logic       r_err;
    logic       r_done;
    logic       w_err;
    logic       w_done;
    logic [7:0] w_exp_byte;

    // E2 sits at two positions, so matching is always by index, never by value.
    always_comb begin
        w_exp_byte = 8'h00;
        case (r_idx)
            3'd0: w_exp_byte = 8'hAF;
            3'd1: w_exp_byte = 8'hBC;
            3'd2: w_exp_byte = 8'hE2;
            3'd3: w_exp_byte = 8'h78;
            3'd4: w_exp_byte = 8'hFF;
            3'd5: w_exp_byte = 8'hE2;
            3'd6: w_exp_byte = 8'h0B;
            3'd7: w_exp_byte = 8'h8D;
            default: w_exp_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_err       = 1'b0;
        w_done      = 1'b0;
        if (data_valid) begin
            case (r_state)
                HUNT: begin
                    if (data_in == START_BYTE) begin
                        w_nxt_state = LOCKED;
                        w_nxt_idx   = 3'd1;
                    end
                end
                LOCKED: begin
                    if (data_in == w_exp_byte) begin
                        w_nxt_idx = r_idx + 3'd1;
                        w_done    = (r_idx == 3'd7);
                    end else begin
                        w_err = 1'b1;
                        // A fresh start byte resyncs in place instead of dropping lock.
                        if (data_in == START_BYTE) begin
                            w_nxt_idx = 3'd1;
                        end else begin
                            w_nxt_state = HUNT;
                            w_nxt_idx   = 3'd0;
                        end
                    end
                end
                default: begin
                    w_nxt_state = HUNT;
                    w_nxt_idx   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= HUNT;
            r_idx   <= 3'd0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_idx   <= w_nxt_idx;
            r_err   <= w_err;
            r_done  <= w_done;
        end
    end

    assign locked    = (r_state == LOCKED);
    assign err_pulse = r_err;
    assign seq_done  = r_done;
    assign dbg_state = r_state;
    assign dbg_idx   = r_idx;

`ifdef SEQ_CHECKER_STATS_EN
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_seq_cnt;

    // Counters follow the same edge as the pulses they count and stick at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_cnt <= '0;
            r_seq_cnt <= '0;
        end else begin
            if (w_err && (r_err_cnt != {CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_done && (r_seq_cnt != {CNT_W{1'b1}})) begin
                r_seq_cnt <= r_seq_cnt + 1'b1;
            end
        end
    end

    assign err_count = r_err_cnt;
    assign seq_count = r_seq_cnt;
`else
    assign err_count = '0;
    assign seq_count = '0;
`endif

endmodule

// File: tb/tb_sequence_checker.sv
// Bench for sequence_checker: a reference model pushes expected output snapshots on
// every driven cycle; they are popped and compared one edge later.
module tb_sequence_checker;

  localparam int CW = 4;
  localparam int VW = 15;

  logic          clk;
  logic          reset;
  logic [7:0]    data_in;
  logic          data_valid;
  logic          locked;
  logic          err_pulse;
  logic          seq_done;
  logic [CW-1:0] err_count;
  logic [CW-1:0] seq_count;
  logic          dbg_state;
  logic [2:0]    dbg_idx;

  int total;
  int bad;

  logic [VW-1:0] exp_q[$];

  logic [7:0]    pat [8];
  logic          m_locked;
  logic [2:0]    m_idx;
  logic          m_err;
  logic          m_done;
  logic [CW-1:0] m_ec;
  logic [CW-1:0] m_sc;
  bit            stats_en;

  sequence_checker #(.CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .seq_done   (seq_done),
    .err_count  (err_count),
    .seq_count  (seq_count),
    .dbg_state  (dbg_state),
    .dbg_idx    (dbg_idx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {dbg_state, dbg_idx, locked, err_pulse, seq_done, err_count, seq_count};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {m_locked, m_idx, m_locked, m_err, m_done, m_ec, m_sc};
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_idx    = 3'd0;
    m_err    = 1'b0;
    m_done   = 1'b0;
    m_ec     = '0;
    m_sc     = '0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    m_err  = 1'b0;
    m_done = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (b == 8'hAF) begin
          m_locked = 1'b1;
          m_idx    = 3'd1;
        end
      end else if (b == pat[m_idx]) begin
        m_done = (m_idx == 3'd7);
        m_idx  = m_idx + 3'd1;
      end else begin
        m_err = 1'b1;
        if (b == 8'hAF) begin
          m_idx = 3'd1;
        end else begin
          m_locked = 1'b0;
          m_idx    = 3'd0;
        end
      end
      if (stats_en && m_err && (m_ec != {CW{1'b1}})) m_ec = m_ec + 1'b1;
      if (stats_en && m_done && (m_sc != {CW{1'b1}})) m_sc = m_sc + 1'b1;
    end
  endtask

  // driver: apply one cycle, push expectation, compare after the edge
  task automatic drive(input string tag, input logic v, input logic [7:0] b);
    @(negedge clk);
    data_valid = v;
    data_in    = b;
    model_step(v, b);
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_empty"}, dut_vec(), '1);
    end else begin
      check(tag, dut_vec(), exp_q.pop_front());
    end
  endtask

  task automatic send_seq(input string tag, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      drive(tag, 1'b1, pat[i]);
      if (gaps) drive({tag, "_gap"}, 1'b0, 8'h5A);
    end
  endtask

  initial begin
    logic [7:0] b;
    int         done_seen;
    pat[0] = 8'hAF; pat[1] = 8'hBC; pat[2] = 8'hE2; pat[3] = 8'h78;
    pat[4] = 8'hFF; pat[5] = 8'hE2; pat[6] = 8'h0B; pat[7] = 8'h8D;
`ifdef SEQ_CHECKER_STATS_EN
    stats_en = 1'b1;
`else
    stats_en = 1'b0;
`endif
    total = 0;
    bad = 0;
    data_valid = 1'b0;
    data_in = 8'h00;
    model_reset();

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", dut_vec(), '0);
    @(negedge clk);
    reset = 1'b1;
    drive("idle0", 1'b0, 8'hAF);
    drive("idle1", 1'b0, 8'hAF);

    // junk then one clean sequence
    drive("junk00", 1'b1, 8'h00);
    drive("junk11", 1'b1, 8'h11);
    send_seq("seq1", 1'b0);

    // two sequences with valid low every other cycle
    send_seq("gap_a", 1'b1);
    send_seq("gap_b", 1'b1);

    // mismatch drops lock, then relock
    drive("e1_af", 1'b1, 8'hAF);
    drive("e1_bc", 1'b1, 8'hBC);
    drive("e1_e2", 1'b1, 8'hE2);
    drive("e1_78", 1'b1, 8'h78);
    drive("e1_bad", 1'b1, 8'h00);
    send_seq("relock", 1'b0);

    // AF mid-sequence resyncs in place
    drive("e2_af", 1'b1, 8'hAF);
    drive("e2_bc", 1'b1, 8'hBC);
    drive("e2_e2", 1'b1, 8'hE2);
    drive("e2_af_resync", 1'b1, 8'hAF);
    for (int i = 1; i < 8; i++) drive("e2_rest", 1'b1, pat[i]);

    // E2 at index 5 must not be accepted at index 2's neighbour
    drive("e3_af", 1'b1, 8'hAF);
    drive("e3_bc", 1'b1, 8'hBC);
    drive("e3_e2", 1'b1, 8'hE2);
    drive("e3_e2_dup", 1'b1, 8'hE2);

    // saturation: 20 errors through a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      drive("sat_af", 1'b1, 8'hAF);
      drive("sat_bad", 1'b1, 8'h33);
    end
    check("err_sat", {11'd0, err_count}, {11'd0, (stats_en ? 4'd15 : 4'd0)});

    // random mix, biased toward the pattern
    done_seen = 0;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0:       b = 8'(  $urandom_range(0, 255));
        1:       b = 8'hAF;
        default: b = m_locked ? pat[m_idx] : 8'hAF;
      endcase
      drive("rand", 1'($urandom_range(0, 3) != 0), b);
      if (seq_done) done_seen++;
    end
    check("rand_done_seen", VW'(done_seen != 0), VW'(1));

    // asynchronous reset mid-sequence
    drive("ar_af", 1'b1, 8'hAF);
    drive("ar_bc", 1'b1, 8'hBC);
    drive("ar_e2", 1'b1, 8'hE2);
    @(negedge clk);
    data_valid = 1'b1;
    data_in = 8'h78;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("async_reset", dut_vec(), '0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    drive("post_rst_bc", 1'b1, 8'hBC);
    send_seq("post_rst_seq", 1'b0);

    check("queue_drained", VW'(exp_q.size()), VW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
